// File: rtl/gpio_reg_arbiter_if.sv
// rtl/gpio_reg_arbiter_if.sv - requester handshake and GPIO register port bundle
interface gpio_reg_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   we;
    logic [2*NREQ-1:0] sel;
    logic [8*NREQ-1:0] wdata;
    logic [NREQ-1:0]   ack;
    logic              err;
    logic [7:0]        rdata;
    logic              busy;
    logic              gpio_busw;
    logic [1:0]        gpio_regsel;
    logic [7:0]        gpio_wdata;
    logic [7:0]        gpio_rdata;

    modport slave (
        input  req, we, sel, wdata, gpio_rdata,
        output ack, err, rdata, busy, gpio_busw, gpio_regsel, gpio_wdata
    );

    modport master (
        output req, we, sel, wdata, gpio_rdata,
        input  ack, err, rdata, busy, gpio_busw, gpio_regsel, gpio_wdata
    );
endinterface

// File: rtl/gpio_reg_arbiter.sv
// rtl/gpio_reg_arbiter.sv - round-robin sequencer sharing the GPIO register port
module gpio_reg_arbiter #(
    parameter int NREQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    gpio_reg_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_CAPT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   win_q, win_d;
    logic            we_q, we_d;
    logic [1:0]      sel_q, sel_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            err_q, err_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            busy_q, busy_d;
    logic            busw_q, busw_d;
    logic [1:0]      regsel_q, regsel_d;
    logic [7:0]      gwdata_q, gwdata_d;

    logic            grant_vld;
    logic [IW-1:0]   grant_idx;

    // Requester index reached by stepping 'off' places after 'base', wrapping at NREQ.
    function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_vld && bus.req[rr_index(ptr_q, k)]) begin
                grant_vld = 1'b1;
                grant_idx = rr_index(ptr_q, k);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        we_d     = we_q;
        sel_d    = sel_q;
        ack_d    = '0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        busw_d   = 1'b0;
        regsel_d = regsel_q;
        gwdata_d = gwdata_q;

        case (state_q)
            S_IDLE: begin
                regsel_d = 2'b00;
                if (grant_vld) begin
                    win_d    = grant_idx;
                    we_d     = bus.we[grant_idx];
                    sel_d    = bus.sel[2*int'(grant_idx) +: 2];
                    busw_d   = bus.we[grant_idx];
                    regsel_d = bus.sel[2*int'(grant_idx) +: 2];
                    gwdata_d = bus.wdata[8*int'(grant_idx) +: 8];
                    ptr_d    = rr_index(grant_idx, 1);
                    state_d  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // The GPIO samples the command at the edge closing this cycle.
                if (we_q) begin
                    ack_d[win_q] = 1'b1;
                    err_d        = ~sel_q[1];
                    state_d      = S_RESP;
                end else begin
                    state_d = S_CAPT;
                end
            end
            S_CAPT: begin
                rdata_d      = bus.gpio_rdata;
                ack_d[win_q] = 1'b1;
                state_d      = S_RESP;
            end
            S_RESP: begin
                regsel_d = 2'b00;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            we_q     <= 1'b0;
            sel_q    <= 2'b00;
            ack_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= 8'h00;
            busy_q   <= 1'b0;
            busw_q   <= 1'b0;
            regsel_q <= 2'b00;
            gwdata_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            busw_q   <= busw_d;
            regsel_q <= regsel_d;
            gwdata_q <= gwdata_d;
        end
    end

    assign bus.ack         = ack_q;
    assign bus.err         = err_q;
    assign bus.rdata       = rdata_q;
    assign bus.busy        = busy_q;
    assign bus.gpio_busw   = busw_q;
    assign bus.gpio_regsel = regsel_q;
    assign bus.gpio_wdata  = gwdata_q;

    a_ack_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack_q));
    a_busw_access: assert property (@(posedge clk) disable iff (!rst_n) busw_q |-> (state_q == S_ACCESS));
endmodule

// File: doc/gpio_reg_arbiter.md
# gpio_reg_arbiter

Round-robin arbiter and sequencer that shares the GPIO block's register port (write strobe, write data, register select, read data) between up to four requesters, such as the APB slave bridge and an on-chip pattern engine. Each requester issues a single register read or write with a req/ack handshake. The arbiter serialises the accesses, drives the GPIO port with the correct cycle timing, and returns read data captured from the GPIO's registered read path.

## Interface
- NREQ, 2: number of requesters, legal range 2..4.
- clk  input  1  clock; the GPIO block runs on the same clock.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  NREQ  per-requester access request; bit i belongs to requester i.
- we  input  NREQ  per-requester access type: 1 = write, 0 = read.
- sel  input  2*NREQ  per-requester register select, bits [2i+1:2i].
- wdata  input  8*NREQ  per-requester write data, bits [8i+7:8i].
- ack  output  NREQ  one-cycle completion pulse to the granted requester.
- err  output  1  valid with ack; 1 = write to read-only select 2'b00 or 2'b01.
- rdata  output  8  read data, valid in the ack cycle of a read.
- busy  output  1  high while a transaction is in flight (any state other than IDLE).
- gpio_busw  output  1  GPIO write strobe.
- gpio_regsel  output  2  GPIO register select: 10 = DIR, 11 = PORT, 0x = PIN.
- gpio_wdata  output  8  GPIO write data.
- gpio_rdata  input  8  GPIO registered read data.

## Operation
- States: IDLE, ACCESS, CAPT, RESP. All outputs are registered.
- IDLE:
  - If any req bit is high, pick the winner by round-robin starting from pointer ptr.
  - Latch the winner's index, we, sel and wdata.
  - Load the gpio_* outputs with the command. A read loads gpio_busw = 0.
  - Move to ACCESS and set ptr = (winner+1) mod NREQ.
  - If no req bit is high, stay in IDLE with gpio_busw = 0, gpio_regsel = 00 and gpio_wdata held.
- ACCESS: the command is on the GPIO port for exactly one cycle.
  - Write: the GPIO updates DIR or PORT at the closing edge. Next state is RESP, with gpio_busw cleared at that edge.
  - Read: the GPIO loads its read data at the closing edge. Next state is CAPT.
- CAPT (read only): capture gpio_rdata into rdata. Next state is RESP.
- RESP:
  - ack[winner] = 1 for exactly one cycle.
  - err = 1 for a write with sel[1] = 0; otherwise err = 0.
  - The GPIO sees gpio_busw = 0 here, and gpio_regsel returns to 00 at the closing edge.
  - Next state is IDLE.
- Requester rules:
  - Hold req, we, sel and wdata stable from assertion through the ack cycle.
  - Drop req at the edge that ends the ack cycle, or keep it high to request again.
  - A requester whose req stays high is re-arbitrated in IDLE with the updated ptr.
- A req bit that drops before its grant is simply not served. No other requester is affected.
- A write to a read-only select still runs the full sequence (the GPIO ignores it) and completes with err = 1.
- A read of 0x returns the GPIO's sampled pin value.
- Commands from non-granted requesters are ignored.

## Timing
- Reset values: state IDLE, ptr = 0, ack = 0, err = 0, rdata = 00, busy = 0, gpio_busw = 0, gpio_regsel = 00, gpio_wdata = 00.
- Asserting rst_n low mid-transaction aborts it immediately: no ack and no further strobe. A write already sampled by the GPIO is not undone.
- With req seen in IDLE in cycle T:
  - The command is on the GPIO port in T+1.
  - Write: ack in T+2, giving 3 cycles per write including IDLE.
  - Read: gpio_rdata valid in T+2, rdata and ack in T+3, giving 4 cycles per read.
- busy is high from T+1 through the ack cycle.
- Simultaneous requests: with ptr = 0 and req = 0011, requester 0 is served first, then requester 1.
- Wrap-around: after a grant to NREQ-1, ptr = 0.
- gpio_busw is high for exactly one cycle per write and never high during a read, CAPT or RESP.
- At most one ack bit is high in any cycle.

## Test plan
- Single write: req0 with we = 1, sel = 11, wdata = A5 → one-cycle gpio_busw pulse with regsel = 11 and wdata = A5 in T+1; GPIO PORT = A5; ack0 in T+2; err = 0.
- Read back: req1 with we = 0, sel = 11 after PORT = A5 → gpio_busw stays 0; rdata = A5 with ack1 in T+3; busy high for T+1..T+3.
- Fairness: NREQ = 3, all req held high and reissued → grants in order 0,1,2,0,1,2; no requester is granted twice while another is pending.
- Read-only write: we = 1, sel = 01, wdata = FF → ack with err = 1; GPIO DIR and PORT unchanged; pins unaffected.
- Reset mid-op: rst_n low during ACCESS of a read → no ack, all outputs at reset values; after release, the first grant goes to requester 0.
- Pin read: DIR = 00 and external pins driven 3C → read with sel = 00 returns 3C; drop req0 before grant while req1 is pending → only ack1 fires.
